// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//
// Characterizes a combinational 3-input gate. The sweeper walks the gate
// inputs through all eight combinations (index = {in1,in2,in3}), holds each
// combination for SETTLE_CYCLES cycles so the gate output can settle, then
// samples the gate output on SAMPLES consecutive edges. The majority of the
// samples becomes one bit of the truth-table code. A combination whose
// samples disagree is flagged in the instability mask.
//
// Parameters
//   SETTLE_CYCLES  cycles each combination is held before sampling (>= 1)
//   SAMPLES        samples per combination (odd, >= 1)
//
// Ports
//   clk          clock; all state changes on the rising edge
//   reset        asynchronous, active-high reset
//   start        sweep request, honoured only while idle
//   expected     expected truth-table code
//   out_sample   output of the gate under characterization
//   in1/in2/in3  stimulus to the gate
//   busy         high from the start-accept edge until the done cycle
//   done         one-cycle pulse when a sweep completes
//   table_valid  truth_table holds a completed sweep
//   truth_table  bit i = majority output sampled at index i
//   unstable     bit i = samples at index i were not unanimous
//   match        table_valid and truth_table == expected (combinational)

module truth_table_sweeper #(
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLES       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] expected,
    input  logic       out_sample,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic       table_valid,
    output logic [7:0] truth_table,
    output logic [7:0] unstable,
    output logic       match
);

    // Counter widths: the settle counter counts 0 .. SETTLE_CYCLES-1, the
    // sample and ones counters must be able to hold the value SAMPLES.
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int OW = (SAMPLES > 1) ? $clog2(SAMPLES + 1) : 1;

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [OW-1:0] SAMPLE_LAST = OW'(SAMPLES - 1);
    localparam logic [OW-1:0] MAJ_LIMIT   = OW'(SAMPLES / 2);
    localparam logic [OW-1:0] ALL_ONES    = OW'(SAMPLES);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SAMPLE,
        COMMIT,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [2:0]      idx;
    logic [SW-1:0]   settle_cnt;
    logic [OW-1:0]   sample_cnt;
    logic [OW-1:0]   ones_cnt;
    logic [2:0]      stim;

    logic            majority;
    logic            split;
    logic [7:0]      table_commit;
    logic [7:0]      unstable_commit;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        stim       = 3'b000;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = APPLY;
                end
            end
            APPLY: begin
                busy = 1'b1;
                stim = idx;
                if (settle_cnt == SETTLE_LAST) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                busy = 1'b1;
                stim = idx;
                // The edge that takes the last sample also leaves SAMPLE,
                // so the ones counter is complete when COMMIT reads it.
                if (sample_cnt == SAMPLE_LAST) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                busy = 1'b1;
                // Inputs stay on idx through COMMIT; they only move on the
                // COMMIT->APPLY edge when idx advances.
                stim = idx;
                if (idx == 3'd7) begin
                    state_next = DONE;
                end else begin
                    state_next = APPLY;
                end
            end
            DONE: begin
                // start is deliberately not looked at here: a request held
                // across DONE is only accepted once back in IDLE.
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in1 = stim[2];
    assign in2 = stim[1];
    assign in3 = stim[0];

    // ------------------------------------------------------------------
    // Per-combination result: majority vote and unanimity check
    // ------------------------------------------------------------------
    assign majority = (ones_cnt > MAJ_LIMIT);
    // With a single sample ones_cnt is always 0 or SAMPLES, so this is 0.
    assign split    = (ones_cnt != '0) && (ones_cnt != ALL_ONES);

    // Only the bit selected by idx is replaced on COMMIT; the others keep
    // the results of earlier combinations.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_commit
            assign table_commit[gi]    = (idx == 3'(gi)) ? majority : truth_table[gi];
            assign unstable_commit[gi] = (idx == 3'(gi)) ? split    : unstable[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Datapath: index, counters and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx         <= 3'd0;
            settle_cnt  <= '0;
            sample_cnt  <= '0;
            ones_cnt    <= '0;
            truth_table <= 8'h00;
            unstable    <= 8'h00;
            table_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // A new sweep discards the previous results.
                        idx         <= 3'd0;
                        settle_cnt  <= '0;
                        sample_cnt  <= '0;
                        ones_cnt    <= '0;
                        truth_table <= 8'h00;
                        unstable    <= 8'h00;
                        table_valid <= 1'b0;
                    end
                end
                APPLY: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    ones_cnt   <= ones_cnt + OW'(out_sample);
                    sample_cnt <= sample_cnt + 1'b1;
                end
                COMMIT: begin
                    truth_table <= table_commit;
                    unstable    <= unstable_commit;
                    settle_cnt  <= '0;
                    sample_cnt  <= '0;
                    ones_cnt    <= '0;
                    if (idx != 3'd7) begin
                        idx <= idx + 3'd1;
                    end
                end
                DONE: begin
                    table_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign match = table_valid && (truth_table == expected);

endmodule
